// File: rtl/obstacle_pkg.sv
// Shared types and default parameters for the obstacle draw engine.
package obstacle_pkg;

  localparam int unsigned COLOUR_W    = 3;
  localparam int unsigned DEF_H_SHORT = 30;
  localparam int unsigned DEF_H_MID   = 60;
  localparam int unsigned DEF_H_TALL  = 90;
  localparam int unsigned DEF_T_MID   = 6;
  localparam int unsigned DEF_T_TALL  = 11;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StDone
  } state_e;

endpackage

// File: rtl/obstacle_lfsr.sv
// Free-running Fibonacci LFSR: shifts left each cycle, feedback enters at bit 0.
module obstacle_lfsr #(
  parameter int unsigned          LFSR_W    = 4,
  parameter logic [LFSR_W-1:0]    LFSR_TAPS = 4'b1100,
  parameter logic [LFSR_W-1:0]    LFSR_SEED = 4'b1110
) (
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  logic              feedback;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    feedback = ^(q & LFSR_TAPS);
    q_d      = {q[LFSR_W-2:0], feedback};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/obstacle_draw_engine.sv
// Rasterises one OBS_W x obs_h rectangle into the VGA pixel port, with an erase
// mode that repaints the last rectangle in the background colour.
module obstacle_draw_engine
  import obstacle_pkg::*;
#(
  parameter int unsigned       COORD_W   = 8,
  parameter int unsigned       OBS_W     = 11,
  parameter int unsigned       H_SHORT   = DEF_H_SHORT,
  parameter int unsigned       H_MID     = DEF_H_MID,
  parameter int unsigned       H_TALL    = DEF_H_TALL,
  parameter int unsigned       LFSR_W    = 4,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 4'b1110,
  parameter int unsigned       T_MID     = DEF_T_MID,
  parameter int unsigned       T_TALL    = DEF_T_TALL
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                erase,
  input  logic [COORD_W-1:0]  x_origin,
  input  logic [COORD_W-1:0]  y_origin,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic                plot_ready,
  output logic [COORD_W-1:0]  plot_x,
  output logic [COORD_W-1:0]  plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot_valid,
  output logic                busy,
  output logic                done,
  output logic [COORD_W-1:0]  obs_h
);

  localparam int unsigned CxW = (OBS_W > 1) ? $clog2(OBS_W) : 1;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_org_q, x_org_d;
  logic [COORD_W-1:0]  y_org_q, y_org_d;
  logic [COLOUR_W-1:0] col_q, col_d;
  logic [COORD_W-1:0]  obs_h_q, obs_h_d;
  logic [CxW-1:0]      cx_q, cx_d;
  logic [COORD_W-1:0]  cy_q, cy_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [COORD_W-1:0]  tier_h;
  logic                cx_last, cy_last;

  obstacle_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Height tier chosen by the LFSR value; every value maps to some tier.
  always_comb begin
    if (32'(lfsr_q) < T_MID) begin
      tier_h = COORD_W'(H_SHORT);
    end else if (32'(lfsr_q) < T_TALL) begin
      tier_h = COORD_W'(H_MID);
    end else begin
      tier_h = COORD_W'(H_TALL);
    end
  end

  assign cx_last = (cx_q == CxW'(OBS_W - 1));
  assign cy_last = (cy_q == obs_h_q - COORD_W'(1));

  always_comb begin
    state_d = state_q;
    x_org_d = x_org_q;
    y_org_d = y_org_q;
    col_d   = col_q;
    obs_h_d = obs_h_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_org_d = x_origin;
          y_org_d = y_origin;
          col_d   = erase ? bg_colour : colour;
          if (!erase) begin
            obs_h_d = tier_h;
          end
          cx_d    = '0;
          cy_d    = '0;
          state_d = StDraw;
        end
      end
      StDraw: begin
        // Counters advance only on an accepted pixel so outputs hold under back-pressure.
        if (plot_ready) begin
          if (cx_last) begin
            cx_d = '0;
            if (cy_last) begin
              state_d = StDone;
            end else begin
              cy_d = cy_q + COORD_W'(1);
            end
          end else begin
            cx_d = cx_q + CxW'(1);
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    plot_valid  = (state_q == StDraw);
    busy        = (state_q != StIdle);
    plot_x      = plot_valid ? x_org_q + COORD_W'(cx_q) : '0;
    plot_y      = plot_valid ? y_org_q + cy_q : '0;
    plot_colour = plot_valid ? col_q : '0;
    obs_h       = obs_h_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      x_org_q <= '0;
      y_org_q <= '0;
      col_q   <= '0;
      obs_h_q <= COORD_W'(H_SHORT);
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      x_org_q <= x_org_d;
      y_org_q <= y_org_d;
      col_q   <= col_d;
      obs_h_q <= obs_h_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

endmodule

// File: tb/tb_obstacle_draw_engine.sv
// Directed bench: table of draw/erase operations plus reset, LFSR and abort sequences.
module tb_obstacle_draw_engine;

  logic       clock;
  logic       reset;
  logic       start;
  logic       erase;
  logic [7:0] x_origin;
  logic [7:0] y_origin;
  logic [2:0] colour;
  logic [2:0] bg_colour;
  logic       plot_ready;
  logic [7:0] plot_x;
  logic [7:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot_valid;
  logic       busy;
  logic       done;
  logic [7:0] obs_h;

  int n_vec;
  int n_fail;

  obstacle_draw_engine dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .erase       (erase),
    .x_origin    (x_origin),
    .y_origin    (y_origin),
    .colour      (colour),
    .bg_colour   (bg_colour),
    .plot_ready  (plot_ready),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .plot_valid  (plot_valid),
    .busy        (busy),
    .done        (done),
    .obs_h       (obs_h)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit rst;
    int wait_n;
    bit erase;
    int x0;
    int y0;
    int col;
    int bg;
    int mode;   // 0: plot_ready high, 1: plot_ready pattern 1,0,0,1
    bit poke;   // assert start (other origin) mid-draw
    int exp_h;
    int exp_n;
    int exp_lx;
    int exp_ly;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int c, n, last_xfer, pix_err, hold_err, busy_err, first_x, first_y, last_x, last_y;
    int ex, ey, ecol, px, py, pc;
    bit got_done, rdy, stalled;
    if (v.rst) begin
      reset = 1'b1;
      start = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
    end
    repeat (v.wait_n) tick();
    start     = 1'b1;
    erase     = v.erase;
    x_origin  = 8'(v.x0);
    y_origin  = 8'(v.y0);
    colour    = 3'(v.col);
    bg_colour = 3'(v.bg);
    tick();
    start = 1'b0;
    ecol = v.erase ? v.bg : v.col;
    c = 1; n = 0; last_xfer = 0; pix_err = 0; hold_err = 0; busy_err = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    got_done = 1'b0; stalled = 1'b0; px = 0; py = 0; pc = 0;
    while (c < 4000) begin
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (plot_valid !== 1'b1) begin
        pix_err++;
      end else begin
        if (stalled && (int'(plot_x) != px || int'(plot_y) != py || int'(plot_colour) != pc))
          hold_err++;
        px = int'(plot_x); py = int'(plot_y); pc = int'(plot_colour);
        rdy = (v.mode == 0) || ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
        plot_ready = rdy;
        if (rdy) begin
          ex = (v.x0 + n % 11) % 256;
          ey = (v.y0 + n / 11) % 256;
          if (px != ex || py != ey || pc != ecol) pix_err++;
          if (n == 0) begin first_x = px; first_y = py; end
          last_x = px; last_y = py;
          n++;
          last_xfer = c;
        end
        stalled = !rdy;
      end
      start    = v.poke && (n >= 20) && (n < 25);
      x_origin = 8'd99;
      tick();
      c++;
    end
    start = 1'b0;
    check("done_seen", int'(got_done), 1);
    check("plot_valid_in_done", int'(plot_valid), 0);
    check("obs_h", int'(obs_h), v.exp_h);
    check("pixel_count", n, v.exp_n);
    check("pixel_values", pix_err, 0);
    check("hold_stable", hold_err, 0);
    check("busy_during_op", busy_err, 0);
    check("first_x", first_x, v.x0);
    check("first_y", first_y, v.y0);
    check("last_x", last_x, v.exp_lx);
    check("last_y", last_y, v.exp_ly);
    check("done_after_last_xfer", c, last_xfer + 1);
    if (v.mode == 0) check("done_latency", c, v.exp_n + 1);
    plot_ready = 1'b1;
    tick();
    check("busy_after_done", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
    check("obs_h_kept", int'(obs_h), v.exp_h);
  endtask

  initial begin
    int seen_bad;
    n_vec = 0; n_fail = 0;
    //            rst wt er  x0   y0 col bg md pk  h    n    lx   ly
    vecs[0] = '{1'b1, 0, 1'b0,  10,  20, 4, 0, 0, 1'b0, 90, 990,  20, 109};
    vecs[1] = '{1'b1, 3, 1'b0,  10,  20, 2, 0, 0, 1'b0, 30, 330,  20,  49};
    vecs[2] = '{1'b0, 0, 1'b1,  10,  20, 5, 0, 0, 1'b0, 30, 330,  20,  49};
    vecs[3] = '{1'b1, 2, 1'b0,   0,   0, 7, 0, 1, 1'b1, 60, 660,  10,  59};
    vecs[4] = '{1'b1, 3, 1'b0, 250, 240, 1, 0, 0, 1'b0, 30, 330,   4,  13};
    vecs[5] = '{1'b1, 0, 1'b1,   5,   5, 6, 3, 0, 1'b0, 30, 330,  15,  34};
    vecs[6] = '{1'b1, 0, 1'b0,  10,  20, 4, 0, 1, 1'b0, 90, 990,  20, 109};
    vecs[7] = '{1'b0, 0, 1'b0,  30,  40, 3, 0, 0, 1'b1, 30, 330,  40,  69};

    reset = 1'b1; start = 1'b1; erase = 1'b0; x_origin = '0; y_origin = '0;
    colour = '0; bg_colour = '0; plot_ready = 1'b1;
    repeat (3) tick();
    check("reset_plot_valid", int'(plot_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_obs_h", int'(obs_h), 30);
    check("reset_plot_x", int'(plot_x), 0);
    check("lfsr_0", int'(dut.u_lfsr.q), 14);
    reset = 1'b0; start = 1'b0;
    tick();
    check("lfsr_1", int'(dut.u_lfsr.q), 12);
    tick();
    check("lfsr_2", int'(dut.u_lfsr.q), 8);
    tick();
    check("lfsr_3", int'(dut.u_lfsr.q), 1);

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // Abort a tall draw with reset after 50 transfers.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    start = 1'b1; erase = 1'b0; x_origin = 8'd60; y_origin = 8'd70; colour = 3'd2;
    plot_ready = 1'b1;
    tick();
    start = 1'b0;
    check("abort_obs_h_before", int'(obs_h), 90);
    repeat (50) tick();
    check("abort_mid_valid", int'(plot_valid), 1);
    reset = 1'b1;
    tick();
    check("abort_plot_valid", int'(plot_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_obs_h", int'(obs_h), 30);
    reset = 1'b0;
    seen_bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (done !== 1'b0 || plot_valid !== 1'b0) seen_bad++;
      tick();
    end
    check("abort_no_done_no_pixels", seen_bad, 0);
    run_op(vecs[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
